// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS multiply/divide unit holding the HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle. Signed ops run the
// unsigned core on operand magnitudes and fix the signs up in the final cycle.
//
// state  | meaning
// S_IDLE | waiting for start; MTHI/MTLO writes accepted
// S_CALC | one core iteration per cycle, counter 0..WIDTH-1
// S_FIN  | sign fix-up, HI/LO written, done pulsed
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;   // multiply: product upper half; divide: remainder
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;   // multiply: multiplier/product lower half; divide: dividend/quotient
    logic [WIDTH-1:0]   opnd_q, opnd_d;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   dvd_raw_q, dvd_raw_d; // dividend as given, returned in HI on divide by zero
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;         // negate product / quotient
    logic               rem_neg_q, rem_neg_d; // remainder follows the dividend's sign
    logic               dbz_flag_q, dbz_flag_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic               signed_op;
    logic [WIDTH-1:0]   rs_mag;
    logic [WIDTH-1:0]   rt_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] prod_raw;
    logic [2*WIDTH-1:0] prod_fin;

    assign signed_op = ~op[0];
    assign rs_mag    = (signed_op && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    assign rt_mag    = (signed_op && rt_val[WIDTH-1]) ? -rt_val : rt_val;

    // One shift-add step: conditional add into the upper half, then shift the whole accumulator right.
    assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);

    // One restoring step: shift the next dividend bit into the remainder and trial-subtract.
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd_q});
    assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;

    assign prod_raw  = {acc_hi_q, acc_lo_q};
    assign prod_fin  = neg_q ? -prod_raw : prod_raw;

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            opnd_q     <= '0;
            dvd_raw_q  <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            dbz_flag_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            opnd_q     <= opnd_d;
            dvd_raw_q  <= dvd_raw_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            dbz_flag_q <= dbz_flag_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
        end
    end

    // Next-state: launch on start, leave CALC after the last iteration, FIN lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CALC;
            S_CALC:  if (cnt_q == LAST_ITER) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and outputs: operand capture, core iterations, result write-back, MTHI/MTLO.
    always_comb begin
        cnt_d      = cnt_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        opnd_d     = opnd_q;
        dvd_raw_d  = dvd_raw_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        dbz_flag_d = dbz_flag_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        dbz_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // A start in the same cycle as MTHI/MTLO takes priority; the MT write is dropped.
                    cnt_d      = '0;
                    is_div_d   = op[1];
                    acc_hi_d   = '0;
                    acc_lo_d   = op[1] ? rs_mag : rt_mag;
                    opnd_d     = op[1] ? rt_mag : rs_mag;
                    dvd_raw_d  = rs_val;
                    neg_d      = signed_op && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                    rem_neg_d  = signed_op && rs_val[WIDTH-1];
                    dbz_flag_d = op[1] && (rt_val == '0);
                end else begin
                    if (mthi) hi_d = wr_data;
                    if (mtlo) lo_d = wr_data;
                end
            end
            S_CALC: begin
                cnt_d = (cnt_q == LAST_ITER) ? '0 : cnt_q + 1'b1;
                if (is_div_q) begin
                    acc_hi_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_hi_d = mul_sum[WIDTH:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                end
            end
            S_FIN: begin
                done_d = 1'b1;
                dbz_d  = dbz_flag_q;
                if (is_div_q) begin
                    if (dbz_flag_q) begin
                        hi_d = dvd_raw_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_neg_q ? -acc_hi_q : acc_hi_q;
                        lo_d = neg_q ? -acc_lo_q : acc_lo_q;
                    end
                end else begin
                    hi_d = prod_fin[2*WIDTH-1:WIDTH];
                    lo_d = prod_fin[WIDTH-1:0];
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: reference model from plain 64-bit arithmetic plus a
// cycle countdown, checked every cycle, and literal expectations for key vectors.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] rs_val = '0;
    logic [W-1:0] rt_val = '0;
    logic         mthi = 1'b0;
    logic         mtlo = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;

    mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .mthi(mthi), .mtlo(mtlo),
        .wr_data(wr_data), .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Result of an operation from architectural rules: {div_by_zero, hi, lo}.
    function automatic logic [64:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ref_result = '0;
        case (o)
            2'd0: begin
                q = sa * sb;
                ref_result = {1'b0, q[63:0]};
            end
            2'd1: begin
                u = {32'b0, a} * {32'b0, b};
                ref_result = {1'b0, u};
            end
            2'd2: begin
                if (b == 0) ref_result = {1'b1, a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    ref_result = {1'b0, r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) ref_result = {1'b1, a, 32'hFFFF_FFFF};
                else ref_result = {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    // Reference model: busy for WIDTH+1 cycles after an accepted start, result lands with done.
    logic        m_valid = 1'b0;
    int          m_rem = 0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic        m_done = 1'b0, m_dbz = 1'b0, p_dbz = 1'b0;

    always @(posedge clk) begin
        m_valid = 1'b1;
        if (reset) begin
            m_rem = 0; m_hi = '0; m_lo = '0; m_done = 1'b0; m_dbz = 1'b0;
        end else begin
            m_done = 1'b0;
            m_dbz  = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; m_dbz = p_dbz;
                end
            end else if (start) begin
                {p_dbz, p_hi, p_lo} = ref_result(op, rs_val, rt_val);
                m_rem = W + 1;
            end else begin
                if (mthi) m_hi = wr_data;
                if (mtlo) m_lo = wr_data;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("cyc_busy", 64'(busy), 64'(m_rem > 0));
            chk("cyc_done", 64'(done), 64'(m_done));
            chk("cyc_dbz",  64'(div_by_zero), 64'(m_dbz));
            chk("cyc_hi",   64'(hi), 64'(m_hi));
            chk("cyc_lo",   64'(lo), 64'(m_lo));
        end
    end

    // Called at a falling edge; returns at the falling edge after the start edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the falling edge of the done cycle, counting busy cycles seen.
    task automatic wait_done(output int busy_cycles);
        busy_cycles = 0;
        for (int i = 0; i < 60; i++) begin
            if (done === 1'b1) return;
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL done_timeout actual=no_done required=done_within_60");
    endtask

    task automatic run(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dbz);
        int bc;
        issue(o, a, b);
        wait_done(bc);
        chk({name, "_busy_cycles"}, 64'(bc), 64'd33);
        chk({name, "_hi"}, 64'(hi), 64'(exp_hi));
        chk({name, "_lo"}, 64'(lo), 64'(exp_lo));
        chk({name, "_dbz"}, 64'(div_by_zero), 64'(exp_dbz));
    endtask

    initial begin
        int bc;
        int done_seen;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run("mult_7_m3", 2'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        // next start issued in the done cycle itself
        run("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run("div_m7_2", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run("divu_100_7", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run("divu_by0", 2'd3, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
        @(negedge clk);
        chk("dbz_one_cycle", 64'(div_by_zero), 64'd0);
        run("div_min_m1", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        run("div_7_m2", 2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
        run("div_m7_by0", 2'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
        run("mult_min_min", 2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
        @(negedge clk);

        // MTHI and MTLO together write both registers.
        mthi = 1'b1; mtlo = 1'b1; wr_data = 32'h5A5A;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        chk("mt_both_hi", 64'(hi), 64'h5A5A);
        chk("mt_both_lo", 64'(lo), 64'h5A5A);

        // Start wins over a simultaneous MTLO; hi/lo hold during the calculation.
        mtlo = 1'b1; wr_data = 32'hDEAD;
        issue(2'd1, 32'd2, 32'd3);
        mtlo = 1'b0;
        repeat (5) @(negedge clk);
        chk("calc_hold_lo", 64'(lo), 64'h5A5A);
        wait_done(bc);
        chk("start_mt_hi", 64'(hi), 64'd0);
        chk("start_mt_lo", 64'(lo), 64'd6);
        @(negedge clk);

        // Start and MTHI while busy are ignored.
        issue(2'd0, 32'd3, 32'd5);
        repeat (8) @(negedge clk);
        start = 1'b1; op = 2'd2; rs_val = 32'd9; rt_val = 32'd3;
        @(negedge clk);
        start = 1'b0; rs_val = '0; rt_val = '0;
        @(negedge clk);
        mthi = 1'b1; wr_data = 32'hAA;
        @(negedge clk);
        mthi = 1'b0;
        wait_done(bc);
        chk("overlap_hi", 64'(hi), 64'd0);
        chk("overlap_lo", 64'(lo), 64'd15);
        @(negedge clk);
        chk("overlap_no_second", 64'(busy), 64'd0);

        // Reset mid-calculation abandons the operation.
        issue(2'd3, 32'd1000, 32'd7);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_hi", 64'(hi), 64'd0);
        chk("rst_mid_lo", 64'(lo), 64'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) done_seen++;
            @(negedge clk);
        end
        chk("rst_mid_no_done", 64'(done_seen), 64'd0);
        mtlo = 1'b1; wr_data = 32'h1234;
        @(negedge clk);
        mtlo = 1'b0;
        chk("mtlo_idle_lo", 64'(lo), 64'h1234);
        chk("mtlo_idle_hi", 64'(hi), 64'd0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
